// File: rtl/hpm_pkg.sv
// Shared constants and types for the hardware performance-monitor counter bank.
package hpm_pkg;

  localparam int HPM_NUM_EVENTS = 8;
  localparam int EVSEL_W        = $clog2(HPM_NUM_EVENTS);

  localparam logic [EVSEL_W-1:0] EV_CYCLE   = EVSEL_W'(0);
  localparam logic [EVSEL_W-1:0] EV_RETIRE  = EVSEL_W'(1);
  localparam logic [EVSEL_W-1:0] EV_CONDBR  = EVSEL_W'(2);
  localparam logic [EVSEL_W-1:0] EV_MISPRED = EVSEL_W'(3);
  localparam logic [EVSEL_W-1:0] EV_LOAD    = EVSEL_W'(4);
  localparam logic [EVSEL_W-1:0] EV_STORE   = EVSEL_W'(5);
  localparam logic [EVSEL_W-1:0] EV_STALL   = EVSEL_W'(6);
  localparam logic [EVSEL_W-1:0] EV_FLUSH   = EVSEL_W'(7);

  typedef struct packed {
    logic               en;
    logic [EVSEL_W-1:0] sel;
  } hpm_cfg_t;

  // Index width for a bank of n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// One programmable counter with sticky overflow and threshold compare; value visible the cycle after inc.
// Wraps past all-ones by default; holds at all-ones when HPM_SATURATE_EN is defined.
module hpm_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 en,
  input  logic                 cnt_we,
  input  logic                 thr_we,
  input  logic [CNT_WIDTH-1:0] wr_data,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [CNT_WIDTH-1:0] thr,
  output logic                 ovf,
  output logic                 hit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      thr <= '1;
      ovf <= 1'b0;
    end else begin
      if (thr_we) thr <= wr_data;
      // A software load takes priority over a coincident event.
      if (cnt_we) begin
        cnt <= wr_data;
        ovf <= 1'b0;
      end else if (inc) begin
        if (&cnt) begin
          ovf <= 1'b1;
`ifdef HPM_SATURATE_EN
          cnt <= cnt;
`else
          cnt <= '0;
`endif
        end else begin
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign hit = en & (cnt >= thr);

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of event-selectable performance counters, threshold interrupt and no-retire watchdog.
// Counter behaviour on overflow is selected by HPM_SATURATE_EN (wrap when undefined).
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter int NUM_COUNTERS = 4,
  parameter int CNT_WIDTH    = 32,
  parameter int NUM_EVENTS   = HPM_NUM_EVENTS,
  parameter int WDOG_WIDTH   = 20,
  localparam int IDX_W       = idx_w(NUM_COUNTERS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_EVENTS-1:0]   event_i,
  input  logic                    freeze_i,
  input  logic                    cnt_we_i,
  input  logic                    sel_we_i,
  input  logic                    thr_we_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [CNT_WIDTH-1:0]    wr_data_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  output logic [CNT_WIDTH-1:0]    rd_cnt_o,
  output logic [CNT_WIDTH-1:0]    rd_thr_o,
  output logic [NUM_COUNTERS-1:0] ovf_o,
  output logic                    thr_irq_o,
  input  logic                    retire_i,
  input  logic [WDOG_WIDTH-1:0]   wdog_limit_i,
  output logic                    wdog_timeout_o
);

  localparam int                 EV_PAD_W  = 1 << EVSEL_W;
  localparam logic [EVSEL_W:0]   NUM_EV_L  = (EVSEL_W + 1)'(NUM_EVENTS);
  localparam logic [IDX_W:0]     NUM_CNT_L = (IDX_W + 1)'(NUM_COUNTERS);

  typedef enum logic {WD_RUN, WD_EXPIRED} wd_state_t;

  logic [EV_PAD_W-1:0]     ev_pad;
  logic                    wr_ok;
  logic [NUM_COUNTERS-1:0] inc;
  logic [NUM_COUNTERS-1:0] hit;
  logic [CNT_WIDTH-1:0]    cnt_q [NUM_COUNTERS];
  logic [CNT_WIDTH-1:0]    thr_q [NUM_COUNTERS];
  wd_state_t               wd_state;
  logic [WDOG_WIDTH-1:0]   wd_cnt;

  // Padding lets any select value index safely; out-of-range selects are masked below.
  assign ev_pad = EV_PAD_W'(event_i);
  assign wr_ok  = {1'b0, wr_idx_i} < NUM_CNT_L;

  for (genvar k = 0; k < NUM_COUNTERS; k++) begin : g_cnt
    hpm_cfg_t cfg;
    logic     wr_hit;

    assign wr_hit = wr_ok && (wr_idx_i == IDX_W'(k));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cfg <= '0;
      else if (sel_we_i && wr_hit) cfg <= hpm_cfg_t'(wr_data_i[EVSEL_W:0]);
    end

    assign inc[k] = cfg.en & ~freeze_i & ({1'b0, cfg.sel} < NUM_EV_L) & ev_pad[cfg.sel];

    hpm_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc[k]),
      .en     (cfg.en),
      .cnt_we (cnt_we_i & wr_hit),
      .thr_we (thr_we_i & wr_hit),
      .wr_data(wr_data_i),
      .cnt    (cnt_q[k]),
      .thr    (thr_q[k]),
      .ovf    (ovf_o[k]),
      .hit    (hit[k])
    );
  end

  always_comb begin
    rd_cnt_o = '0;
    rd_thr_o = '0;
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      if (rd_idx_i == IDX_W'(k)) begin
        rd_cnt_o = cnt_q[k];
        rd_thr_o = thr_q[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) thr_irq_o <= 1'b0;
    else     thr_irq_o <= |hit;
  end

  // Watchdog ignores freeze_i: it guards forward progress, not measurement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_state       <= WD_RUN;
      wd_cnt         <= '0;
      wdog_timeout_o <= 1'b0;
    end else begin
      case (wd_state)
        WD_RUN: begin
          if (wdog_limit_i == '0 || retire_i) begin
            wd_cnt <= '0;
          end else if (wd_cnt == wdog_limit_i - WDOG_WIDTH'(1)) begin
            wd_state       <= WD_EXPIRED;
            wdog_timeout_o <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WDOG_WIDTH'(1);
          end
        end
        default: begin
          wd_state       <= WD_EXPIRED;
          wdog_timeout_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Scoreboard bench for hpm_counter_bank: directed scenarios plus random traffic against a reference model.
module tb_hpm_counter_bank;
  import hpm_pkg::*;

`ifdef HPM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint MAXV = 64'hFFFF_FFFF;

  logic        clk, rst;
  logic [7:0]  event_i;
  logic        freeze_i, cnt_we_i, sel_we_i, thr_we_i, retire_i;
  logic [1:0]  wr_idx_i, rd_idx_i;
  logic [31:0] wr_data_i, rd_cnt_o, rd_thr_o;
  logic [3:0]  ovf_o;
  logic        thr_irq_o, wdog_timeout_o;
  logic [19:0] wdog_limit_i;

  hpm_counter_bank dut (
    .clk(clk), .rst(rst), .event_i(event_i), .freeze_i(freeze_i),
    .cnt_we_i(cnt_we_i), .sel_we_i(sel_we_i), .thr_we_i(thr_we_i),
    .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i), .rd_idx_i(rd_idx_i),
    .rd_cnt_o(rd_cnt_o), .rd_thr_o(rd_thr_o), .ovf_o(ovf_o),
    .thr_irq_o(thr_irq_o), .retire_i(retire_i), .wdog_limit_i(wdog_limit_i),
    .wdog_timeout_o(wdog_timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cnt;
    logic [31:0] thr;
    logic [3:0]  ovf;
    logic        irq;
    logic        wdog;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model state
  longint m_cnt [4];
  longint m_thr [4];
  bit     m_en  [4];
  int     m_sel [4];
  bit     m_ovf [4];
  bit     m_irq;
  int     m_wcnt;
  bit     m_wexp;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0; m_thr[k] = MAXV; m_en[k] = 0; m_sel[k] = 0; m_ovf[k] = 0;
    end
    m_irq = 0; m_wcnt = 0; m_wexp = 0;
  endtask

  // Advance the model across the coming posedge and queue what the DUT must show after it.
  task automatic model_step();
    bit     any_hit;
    bit     counts;
    longint nxt;
    exp_t   e;
    any_hit = 0;
    for (int k = 0; k < 4; k++)
      if (m_en[k] && m_cnt[k] >= m_thr[k]) any_hit = 1;
    if (!m_wexp) begin
      if (wdog_limit_i == 0 || retire_i) m_wcnt = 0;
      else if (m_wcnt + 1 == int'(wdog_limit_i)) m_wexp = 1;
      else m_wcnt = m_wcnt + 1;
    end
    for (int k = 0; k < 4; k++) begin
      counts = m_en[k] && !freeze_i && m_sel[k] < 8 && event_i[m_sel[k]];
      if (cnt_we_i && int'(wr_idx_i) == k) begin
        m_cnt[k] = longint'(wr_data_i);
        m_ovf[k] = 0;
      end else if (counts) begin
        nxt = m_cnt[k] + 1;
        if (nxt > MAXV) begin
          m_ovf[k] = 1;
          m_cnt[k] = SAT ? MAXV : nxt - (MAXV + 1);
        end else begin
          m_cnt[k] = nxt;
        end
      end
    end
    if (thr_we_i) m_thr[wr_idx_i] = longint'(wr_data_i);
    if (sel_we_i) begin
      m_en[wr_idx_i]  = wr_data_i[3];
      m_sel[wr_idx_i] = int'(wr_data_i[2:0]);
    end
    m_irq = any_hit;
    e.cnt  = m_cnt[rd_idx_i][31:0];
    e.thr  = m_thr[rd_idx_i][31:0];
    for (int k = 0; k < 4; k++) e.ovf[k] = m_ovf[k];
    e.irq  = m_irq;
    e.wdog = m_wexp;
    q.push_back(e);
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
  endtask

  task automatic wr_sel(input int idx, input bit en, input int sel);
    wr_idx_i = 2'(idx); wr_data_i = {28'b0, en, 3'(sel)}; sel_we_i = 1; cyc(); sel_we_i = 0;
  endtask

  task automatic wr_cnt(input int idx, input logic [31:0] d);
    wr_idx_i = 2'(idx); wr_data_i = d; cnt_we_i = 1; cyc(); cnt_we_i = 0;
  endtask

  task automatic wr_thr(input int idx, input logic [31:0] d);
    wr_idx_i = 2'(idx); wr_data_i = d; thr_we_i = 1; cyc(); thr_we_i = 0;
  endtask

  task automatic rand_cycle();
    event_i   = 8'($urandom);
    freeze_i  = ($urandom_range(0, 9) == 0);
    retire_i  = ($urandom_range(0, 15) == 0);
    rd_idx_i  = 2'($urandom);
    wr_idx_i  = 2'($urandom);
    cnt_we_i  = ($urandom_range(0, 19) == 0);
    sel_we_i  = ($urandom_range(0, 9) == 0);
    thr_we_i  = ($urandom_range(0, 14) == 0);
    case ($urandom_range(0, 3))
      0:       wr_data_i = $urandom;
      1:       wr_data_i = 32'($urandom_range(0, 40));
      2:       wr_data_i = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
      default: wr_data_i = {28'b0, 4'($urandom)};
    endcase
    cyc();
  endtask

  task automatic quiet();
    event_i = 0; freeze_i = 0; retire_i = 0;
    cnt_we_i = 0; sel_we_i = 0; thr_we_i = 0; wr_data_i = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cnt"},  64'(rd_cnt_o),  64'd0);
    chk({tag, "_thr"},  64'(rd_thr_o),  64'hFFFF_FFFF);
    chk({tag, "_ovf"},  64'(ovf_o),     64'd0);
    chk({tag, "_irq"},  64'(thr_irq_o), 64'd0);
    chk({tag, "_wdog"}, 64'(wdog_timeout_o), 64'd0);
  endtask

  // Monitor: compares every registered edge against the scoreboard entry queued for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_rd_cnt", 64'(rd_cnt_o),       64'(e.cnt));
        chk("sb_rd_thr", 64'(rd_thr_o),       64'(e.thr));
        chk("sb_ovf",    64'(ovf_o),          64'(e.ovf));
        chk("sb_irq",    64'(thr_irq_o),      64'(e.irq));
        chk("sb_wdog",   64'(wdog_timeout_o), 64'(e.wdog));
      end
    end
  end

  initial begin
    longint frozen;
    rst = 1; quiet(); wr_idx_i = 0; rd_idx_i = 0; wdog_limit_i = 0;
    model_reset();
    #2;
    chk_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst = 0;

    // Counter 0 counts retire events
    wr_sel(0, 1, EV_RETIRE);
    for (int i = 0; i < 30; i++) begin
      event_i = (i % 3 == 0) ? 8'h02 : 8'h00;
      cyc();
    end
    event_i = 0; rd_idx_i = 0; #1;
    chk("retire_cnt", 64'(rd_cnt_o), 64'd10);
    chk("retire_ovf", 64'(ovf_o[0]), 64'd0);

    // Counter 1 wraps (or saturates) on cycle events
    wr_sel(1, 1, EV_CYCLE);
    event_i = 8'h01;
    wr_cnt(1, 32'hFFFF_FFFE);
    repeat (3) cyc();
    event_i = 0; rd_idx_i = 1; #1;
    chk("wrap_cnt", 64'(rd_cnt_o), SAT ? 64'hFFFF_FFFF : 64'd1);
    chk("wrap_ovf", 64'(ovf_o[1]), 64'd1);
    wr_sel(1, 0, EV_CYCLE);

    // Counter 2: load beats a coincident event and clears overflow
    wr_sel(2, 1, EV_LOAD);
    wr_cnt(2, 32'hFFFF_FFFF);
    event_i = 8'h10;
    cyc();
    chk("c2_ovf_set", 64'(ovf_o[2]), 64'd1);
    wr_cnt(2, 32'h100);
    event_i = 0; rd_idx_i = 2; #1;
    chk("collide_cnt", 64'(rd_cnt_o), 64'h100);
    chk("collide_ovf", 64'(ovf_o[2]), 64'd0);

    // Counter 3 threshold interrupt timing
    wr_thr(3, 32'd5);
    wr_sel(3, 1, EV_MISPRED);
    rd_idx_i = 3;
    for (int p = 1; p <= 5; p++) begin
      event_i = 8'h08; cyc();
      event_i = 0;
      if (p == 5) chk("irq_not_yet", 64'(thr_irq_o), 64'd0);
      cyc();
      if (p == 5) chk("irq_rise", 64'(thr_irq_o), 64'd1);
    end
    wr_thr(3, 32'hFFFF_FFFF);
    chk("irq_hold_on_wr", 64'(thr_irq_o), 64'd1);
    cyc();
    chk("irq_fall", 64'(thr_irq_o), 64'd0);

    // Watchdog with a freeze window after the final retire
    wr_sel(0, 1, EV_CYCLE);
    event_i = 8'h01; rd_idx_i = 0;
    wdog_limit_i = 20'd100;
    for (int r = 0; r < 3; r++) begin
      retire_i = 1; cyc(); retire_i = 0;
      repeat (49) cyc();
    end
    chk("wdog_alive", 64'(wdog_timeout_o), 64'd0);
    retire_i = 1; cyc(); retire_i = 0;
    freeze_i = 1;
    frozen = m_cnt[0];
    repeat (20) cyc();
    #1;
    chk("freeze_cnt", 64'(rd_cnt_o), 64'(frozen));
    freeze_i = 0;
    repeat (79) cyc();
    chk("wdog_edge_minus1", 64'(wdog_timeout_o), 64'd0);
    cyc();
    chk("wdog_expire", 64'(wdog_timeout_o), 64'd1);
    repeat (10) cyc();
    chk("wdog_sticky", 64'(wdog_timeout_o), 64'd1);

    // Random traffic, asynchronous reset mid-cycle, more random traffic
    repeat (300) rand_cycle();
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    quiet();
    @(negedge clk);
    rst = 0;
    wdog_limit_i = 20'($urandom_range(20, 60));
    repeat (400) rand_cycle();
    quiet();

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
